// File: rtl/bus8088_pkg.sv
// Shared types and constants for the 8088 minimum-mode bus models.
package bus8088_pkg;

  localparam int unsigned ADDR_W = 20;
  localparam int unsigned DATA_W = 8;

  localparam logic IOM_IO  = 1'b1;
  localparam logic IOM_MEM = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT,
    READ,
    WRITE
  } resp_state_t;

endpackage

// File: rtl/bus8088_addr_latch.sv
// ALE capture of the demultiplexed address and IO/M status, plus window-hit decode.
module bus8088_addr_latch
  import bus8088_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 20'hF0000,
  parameter int unsigned       DEPTH_LOG2 = 4,
  parameter logic              IO_SPACE   = IOM_IO
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         ale_i,
  input  logic                         iom_i,
  input  logic [ADDR_W-DATA_W-1:0]     a_i,
  input  logic [DATA_W-1:0]            ad_i,
  output logic                         hit_o,
  output logic [DEPTH_LOG2-1:0]        index_o
);

  logic [ADDR_W-1:0] addr_q;
  logic              iom_q;

  // Latches on every ALE-high edge so the last sample of a stretched ALE wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
      iom_q  <= ~IO_SPACE;
    end else if (ale_i) begin
      addr_q <= {a_i, ad_i};
      iom_q  <= iom_i;
    end
  end

  always_comb begin
    hit_o   = (iom_q == IO_SPACE) &&
              (addr_q[ADDR_W-1:DEPTH_LOG2] == BASE_ADDR[ADDR_W-1:DEPTH_LOG2]);
    index_o = addr_q[DEPTH_LOG2-1:0];
  end

endmodule

// File: rtl/bus8088_periph_responder.sv
// Slave-side responder for the 8088 multiplexed bus: window decode, wait states,
// and a small register file served over the AD bus.
module bus8088_periph_responder
  import bus8088_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 20'hF0000,
  parameter int unsigned       DEPTH_LOG2  = 4,
  parameter logic              IO_SPACE    = IOM_IO,
  parameter int unsigned       WAIT_STATES = 1
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     ALE,
  input  logic                     IOM,
  input  logic                     RD,
  input  logic                     WR,
  input  logic [ADDR_W-DATA_W-1:0] A,
  inout  wire  [DATA_W-1:0]        AD,
  output logic                     READY,
  output logic                     SEL,
  output logic                     ERR
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  resp_state_t           state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  is_wr_q, is_wr_d;
  logic                  wr_done_q, wr_done_d;
  logic                  err_q, err_d;
  logic [DATA_W-1:0]     rdata_q;
  logic [DATA_W-1:0]     mem_q [Depth];
  logic                  mem_we;
  logic                  strobe_ok;
  logic                  rd_lo, wr_lo;
  logic                  ad_oe;
  logic                  hit;
  logic [DEPTH_LOG2-1:0] index;

  bus8088_addr_latch #(
    .BASE_ADDR (BASE_ADDR),
    .DEPTH_LOG2(DEPTH_LOG2),
    .IO_SPACE  (IO_SPACE)
  ) u_addr_latch (
    .clk_i  (CLK),
    .rst_ni (RESET),
    .ale_i  (ALE),
    .iom_i  (IOM),
    .a_i    (A),
    .ad_i   (AD),
    .hit_o  (hit),
    .index_o(index)
  );

  assign rd_lo = !RD;
  assign wr_lo = !WR;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_wr_d   = is_wr_q;
    wr_done_d = wr_done_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    strobe_ok = is_wr_q ? (wr_lo && !rd_lo) : (rd_lo && !wr_lo);

    // A fresh ALE pre-empts whatever cycle is in flight.
    if (state_q != IDLE && ALE) begin
      state_d = ADDR;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ALE) state_d = ADDR;
        end
        ADDR: begin
          if (!hit) begin
            state_d = IDLE;
          end else if (rd_lo && wr_lo) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (rd_lo || wr_lo) begin
            is_wr_d   = wr_lo;
            wr_done_d = 1'b0;
            if (WAIT_STATES > 0) begin
              state_d = WAIT;
              cnt_d   = 4'(WAIT_STATES - 1);
            end else begin
              state_d = wr_lo ? WRITE : READ;
            end
          end
        end
        WAIT: begin
          if (!strobe_ok) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (cnt_q == '0) begin
            state_d = is_wr_q ? WRITE : READ;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        READ: begin
          if (rd_lo && wr_lo) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (!rd_lo) begin
            state_d = IDLE;
          end
        end
        WRITE: begin
          if (rd_lo && wr_lo) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (!wr_lo) begin
            state_d = IDLE;
          end else if (!wr_done_q) begin
            mem_we    = 1'b1;
            wr_done_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_wr_q   <= 1'b0;
      wr_done_q <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_wr_q   <= is_wr_d;
      wr_done_q <= wr_done_d;
      err_q     <= err_d;
      if (state_d == READ && state_q != READ) rdata_q <= mem_q[index];
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[index] <= AD;
    end
  end

  // Drive enable follows RD combinationally so AD lets go in the same cycle RD rises.
  assign ad_oe = (state_q == READ) && rd_lo && !ALE;
  assign AD    = ad_oe ? rdata_q : 'z;

  assign READY = (state_q != WAIT);
  assign SEL   = hit && (state_q != IDLE);
  assign ERR   = err_q;

endmodule

// File: tb/tb_bus8088_periph_responder.sv
// Two responders with disjoint I/O windows sharing one AD bus, checked every cycle.
module tb_bus8088_periph_responder;

  localparam logic [19:0] BASE0 = 20'hF0000;
  localparam logic [19:0] BASE1 = 20'hF0100;
  localparam int          WS0   = 1;
  localparam int          WS1   = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, ale, iom, rd, wr, ad_en;
  logic [11:0] a;
  logic [7:0]  ad_val;
  wire  [7:0]  ad;
  logic [1:0]  ready, sel, err;

  // Released bus reads as all ones.
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (ad[g]);
  end
  assign ad = ad_en ? ad_val : 8'hzz;

  bus8088_periph_responder #(
    .BASE_ADDR(BASE0), .DEPTH_LOG2(4), .IO_SPACE(1'b1), .WAIT_STATES(WS0)
  ) u_dut0 (
    .CLK(clk), .RESET(rst_n), .ALE(ale), .IOM(iom), .RD(rd), .WR(wr), .A(a), .AD(ad),
    .READY(ready[0]), .SEL(sel[0]), .ERR(err[0])
  );

  bus8088_periph_responder #(
    .BASE_ADDR(BASE1), .DEPTH_LOG2(4), .IO_SPACE(1'b1), .WAIT_STATES(WS1)
  ) u_dut1 (
    .CLK(clk), .RESET(rst_n), .ALE(ale), .IOM(iom), .RD(rd), .WR(wr), .A(a), .AD(ad),
    .READY(ready[1]), .SEL(sel[1]), .ERR(err[1])
  );

  int checks = 0;
  int failures = 0;

  logic [7:0] mem_m [2][16];
  logic [1:0] err_m;
  logic [1:0] e_ready, e_sel, e_err;
  logic [7:0] e_ad;
  logic       chk_en;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ws_of(input int k);
    return (k == 0) ? WS0 : WS1;
  endfunction

  function automatic logic hit_of(input int k, input logic iomv, input logic [19:0] addr);
    logic [19:0] b;
    b = (k == 0) ? BASE0 : BASE1;
    return iomv && ((addr >> 4) == (b >> 4));
  endfunction

  task automatic idle_exp();
    for (int k = 0; k < 2; k++) begin
      e_ready[k] = 1'b1;
      e_sel[k]   = 1'b0;
      e_err[k]   = err_m[k];
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++) mem_m[k][i] = 8'h00;
    err_m = 2'b00;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("ready%0d", k), {7'b0, ready[k]}, {7'b0, e_ready[k]});
        chk($sformatf("sel%0d", k), {7'b0, sel[k]}, {7'b0, e_sel[k]});
        chk($sformatf("err%0d", k), {7'b0, err[k]}, {7'b0, e_err[k]});
      end
      chk("ad", ad, e_ad);
    end
  end

  // kind: 0 read, 1 write, 2 both strobes. abort_at: interval index at which to hand
  // control back with strobes still applied (0 = full cycle). busy: responder that is
  // still in a wait state when this cycle's ALE arrives (-1 = none).
  task automatic bus_cycle(input logic iomv, input logic [19:0] addr, input int kind,
                           input logic [7:0] data, input int abort_at, input int busy);
    int hk;
    int idx;
    int ws;
    hk = -1;
    for (int k = 0; k < 2; k++) if (hit_of(k, iomv, addr)) hk = k;
    idx = int'(addr & 20'hF);
    ws  = (hk >= 0) ? ws_of(hk) : 0;

    ale = 1'b1; iom = iomv; a = addr[19:8]; ad_en = 1'b1; ad_val = addr[7:0];
    rd = 1'b1; wr = 1'b1;
    idle_exp();
    if (busy >= 0) begin
      e_ready[busy] = 1'b0;
      e_sel[busy]   = 1'b1;
    end
    e_ad = addr[7:0];
    step();

    ale = 1'b0;
    rd = (kind == 1); wr = (kind == 0);
    ad_en = (kind == 1); ad_val = data;
    idle_exp();
    if (hk >= 0) e_sel[hk] = 1'b1;
    e_ad = (kind == 1) ? data : 8'hFF;
    step();

    if (kind == 2 || hk < 0) begin
      if (kind == 2 && hk >= 0) err_m[hk] = 1'b1;
      rd = 1'b1; wr = 1'b1; ad_en = 1'b0;
      idle_exp();
      e_ad = 8'hFF;
      step();
      return;
    end

    for (int j = 2; j <= ws + 3; j++) begin
      if (abort_at == j) return;
      idle_exp();
      e_sel[hk]   = 1'b1;
      e_ready[hk] = (j > ws + 1);
      e_ad = (kind == 1) ? data : ((j > ws + 1) ? mem_m[hk][idx] : 8'hFF);
      step();
      if (kind == 1 && j == ws + 2) mem_m[hk][idx] = data;
    end

    rd = 1'b1; wr = 1'b1; ad_en = 1'b0;
    idle_exp();
    e_sel[hk] = 1'b1;
    e_ad = 8'hFF;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    chk_en = 1'b0;
    rst_n = 1'b0; ale = 1'b0; iom = 1'b0; rd = 1'b1; wr = 1'b1;
    a = '0; ad_en = 1'b0; ad_val = '0;
    clear_model();
    idle_exp();
    e_ad = 8'hFF;
    #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    bus_cycle(1'b1, 20'hF0003, 1, 8'h5A, 0, -1);
    bus_cycle(1'b1, 20'hF0003, 0, 8'h00, 0, -1);
    bus_cycle(1'b0, 20'hF0003, 0, 8'h00, 0, -1);

    bus_cycle(1'b1, 20'hF000F, 1, 8'h11, 0, -1);
    bus_cycle(1'b1, 20'hF001F, 1, 8'h22, 0, -1);
    bus_cycle(1'b1, 20'hF000F, 0, 8'h00, 0, -1);

    bus_cycle(1'b1, 20'hF0105, 1, 8'h77, 0, -1);
    bus_cycle(1'b1, 20'hF0105, 0, 8'h00, 0, -1);

    // ALE lands in the second of three wait cycles; the write must be dropped.
    bus_cycle(1'b1, 20'hF0106, 1, 8'h99, 3, -1);
    bus_cycle(1'b1, 20'hF0106, 0, 8'h00, 0, 1);

    bus_cycle(1'b1, 20'hF0000, 2, 8'h00, 0, -1);
    @(negedge clk);
    chk("err_sticky", {7'b0, err[0]}, 8'h01);
    @(posedge clk);
    #1;
    bus_cycle(1'b1, 20'hF0000, 0, 8'h00, 0, -1);

    // Reset in the middle of a driven read.
    bus_cycle(1'b1, 20'hF000F, 0, 8'h00, WS0 + 3, -1);
    idle_exp();
    e_sel[0] = 1'b1;
    e_ad = mem_m[0][15];
    @(negedge clk);
    chk("read_mid", ad, 8'h11);
    #1;
    rst_n = 1'b0;
    clear_model();
    idle_exp();
    e_ad = 8'hFF;
    #1;
    chk("rst_ad_release", ad, 8'hFF);
    chk("rst_ready", {7'b0, ready[0]}, 8'h01);
    chk("rst_sel", {7'b0, sel[0]}, 8'h00);
    chk("rst_err", {7'b0, err[0]}, 8'h00);
    @(posedge clk);
    #1 rd = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;

    bus_cycle(1'b1, 20'hF000F, 0, 8'h00, 0, -1);
    bus_cycle(1'b1, 20'hF0003, 0, 8'h00, 0, -1);
    bus_cycle(1'b1, 20'hF0105, 0, 8'h00, 0, -1);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus8088_periph_responder.md
Name: bus8088_periph_responder

Overview:
- Peripheral-side responder for the 8088 minimum-mode multiplexed bus; the slave end of the cycles the processor model initiates.
- Demultiplexes AD/A on ALE, decodes an address window in memory or I/O space, and serves reads and writes from an internal register file.
- Inserts programmable wait states via READY.
- Sits on the shared bus interface alongside the processor model; multiple instances with disjoint windows may coexist.

Parameters:
- BASE_ADDR, 20'hF0000, window base; low DEPTH_LOG2 bits ignored.
- DEPTH_LOG2, 4, register file holds 2**DEPTH_LOG2 bytes.
- IO_SPACE, 1'b1, required IOM value for a hit (1 = I/O, 0 = memory).
- WAIT_STATES, 1, READY-low cycles inserted per selected cycle, 0..15.

Ports:
- CLK  input  1  bus clock; all state updates on posedge.
- RESET  input  1  asynchronous, active-low reset.
- ALE  input  1  address latch enable, active high.
- IOM  input  1  IO/M status.
- RD  input  1  read strobe, active low.
- WR  input  1  write strobe, active low.
- A  input  12  address bits [19:8].
- AD  inout  8  multiplexed address[7:0]/data; driven only during a selected read.
- READY  output  1  wait-state request; low stretches the cycle.
- SEL  output  1  high while the latched address hits the window.
- ERR  output  1  sticky protocol-error flag.

Behaviour:
- Reset (RESET low, async): state=IDLE, READY=1, AD released (Z), SEL=0, ERR=0, register file cleared to 8'h00, wait counter=0.
- Address latch:
  - Every posedge with ALE=1 captures addr_q={A,AD} and iom_q=IOM. The last ALE-high sample wins.
  - hit = (iom_q==IO_SPACE) && (addr_q[19:DEPTH_LOG2]==BASE_ADDR[19:DEPTH_LOG2]).
  - index = addr_q[DEPTH_LOG2-1:0].
- FSM states: IDLE, ADDR, WAIT, READ, WRITE.
  - IDLE: ALE=1 -> ADDR.
  - ADDR:
    - !hit -> IDLE, bus untouched.
    - hit, RD=0 and WR=0 -> set ERR, go IDLE.
    - hit, RD=0 or WR=0 -> WAIT if WAIT_STATES>0, otherwise READ/WRITE directly.
    - Neither strobe low -> remain in ADDR.
  - WAIT:
    - READY=0 for exactly WAIT_STATES cycles (counter loaded on entry).
    - When the counter reaches 0, READY returns to 1 and the FSM goes to READ or WRITE according to the recorded strobe.
  - READ:
    - rdata registered from mem[index] on entry.
    - AD = rdata while state==READ && RD==0. Output enable is combinational on RD so AD releases the same cycle RD rises.
    - RD=1 sampled -> IDLE.
  - WRITE:
    - On the first posedge in WRITE with WR=0, mem[index]<=AD. Exactly one write per cycle.
    - WR=1 sampled -> IDLE.
- SEL = hit && state!=IDLE.
- READY is 1 in every state except WAIT.
- Boundary conditions:
  - ALE=1 in any non-IDLE state: abort the current cycle; release AD, READY=1, no memory write; re-latch and go to ADDR.
  - Strobe deasserts during WAIT: set ERR, go IDLE, no access.
  - Both strobes low in READ/WRITE: set ERR, release AD, go IDLE.
  - index wraps within the window; no address out of range once hit.
  - RESET mid-cycle: immediate return to reset values, including AD release.
- ERR clears only on reset.

Decomposition:
- Package bus8088_pkg holds:
  - typedef enum resp_state_t {IDLE, ADDR, WAIT, READ, WRITE};
  - IOM_IO=1'b1 and IOM_MEM=1'b0 constants;
  - ADDR_W=20 and DATA_W=8.
- One natural sub-module, bus8088_addr_latch: ALE capture of {A,AD} and IOM, plus window-hit compare. The parent holds the FSM, wait counter, register file and AD tristate.

Test Plan:
- I/O write 8'h5A to 20'hF0003 (IOM=1, WAIT_STATES=1) -> READY low exactly 1 cycle; mem[3]=8'h5A; AD never driven by the DUT.
- I/O read 20'hF0003 after that write -> READY low 1 cycle; AD=8'h5A while RD low; AD returns to Z the cycle RD rises; SEL high throughout.
- Memory read to 20'hF0003 (IOM=0, IO_SPACE=1) -> no hit; READY stays 1; AD untouched; SEL=0.
- Write 8'h11 to 20'hF000F, then 20'hF001F (outside window), then read 20'hF000F -> reads 8'h11; second access ignored.
- RD and WR both low after a hit on 20'hF0000 -> ERR=1 (sticky); no write; AD Z. Then RESET low -> ERR=0 and all registers 8'h00.
- WAIT_STATES=3 with ALE re-asserted in the 2nd wait cycle -> cycle aborted; READY=1 next cycle; new address latched; no write occurs.
